// File: rtl/dram_access_arbiter.sv
// Two-requester arbiter for the shared DRAM command port: image prefetch reads vs host writes.
// One grant at a time, held from acceptance until the DRAM master reports completion.
module dram_access_arbiter #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_WAIT        = 255,
    parameter int WAIT_WIDTH      = 8
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic                       rd_req_valid,
    input  logic [DRAM_ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [LEN_WIDTH-1:0]       rd_req_len,
    input  logic                       rd_urgent,
    output logic                       rd_req_ready,
    output logic                       rd_done,
    input  logic                       wr_req_valid,
    input  logic [DRAM_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [LEN_WIDTH-1:0]       wr_req_len,
    output logic                       wr_req_ready,
    output logic                       wr_done,
    output logic                       dram_cmd_valid,
    input  logic                       dram_cmd_ready,
    output logic                       dram_cmd_write,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_cmd_addr,
    output logic [LEN_WIDTH-1:0]       dram_cmd_len,
    input  logic                       dram_done,
    output logic                       busy,
    output logic [15:0]                wr_starve_events
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] MAX_WAIT_C = WAIT_WIDTH'(MAX_WAIT);

    state_t                     state_q, state_d;
    logic                       arm_q, arm_d;
    logic                       last_wr_q, last_wr_d;
    logic [WAIT_WIDTH-1:0]      wait_cnt_q, wait_cnt_d;
    logic [15:0]                starve_q, starve_d;
    logic                       cmd_valid_q, cmd_valid_d;
    logic                       cmd_write_q, cmd_write_d;
    logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_WIDTH-1:0]       cmd_len_q, cmd_len_d;
    logic                       rd_done_q, rd_done_d;
    logic                       wr_done_q, wr_done_d;
    logic                       busy_q, busy_d;

    logic both_valid;
    logic starve_hit;
    logic grant_rd;
    logic grant_wr;

    assign both_valid = rd_req_valid && wr_req_valid;
    assign starve_hit = both_valid && (wait_cnt_q >= MAX_WAIT_C);

    // arm_q is low in reset, in the first cycle after reset and in the done-pulse cycle,
    // so the combinational ready pulses stay quiet there and the inter-grant bubble appears.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == ST_IDLE && arm_q) begin
            if (rd_req_valid && !wr_req_valid) begin
                grant_rd = 1'b1;
            end else if (wr_req_valid && !rd_req_valid) begin
                grant_wr = 1'b1;
            end else if (starve_hit) begin
                grant_wr = 1'b1;
            end else if (both_valid && rd_urgent) begin
                grant_rd = 1'b1;
            end else if (both_valid) begin
                grant_rd = last_wr_q;
                grant_wr = !last_wr_q;
            end
        end
    end

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        starve_d    = starve_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d     = ST_ISSUE;
                    cmd_write_d = grant_wr;
                    cmd_addr_d  = grant_wr ? wr_req_addr : rd_req_addr;
                    cmd_len_d   = grant_wr ? wr_req_len : rd_req_len;
                    if (grant_wr && starve_hit && rd_urgent && starve_q != 16'hFFFF) begin
                        starve_d = starve_q + 16'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (dram_cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dram_done) begin
                    state_d   = ST_IDLE;
                    rd_done_d = !cmd_write_q;
                    wr_done_d = cmd_write_q;
                    last_wr_d = cmd_write_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!wr_req_valid || grant_wr) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        arm_d       = (state_d == ST_IDLE) && (state_q != ST_WAIT);
        cmd_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            last_wr_q   <= 1'b1;
            wait_cnt_q  <= '0;
            starve_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            last_wr_q   <= last_wr_d;
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_req_ready     = grant_rd;
    assign wr_req_ready     = grant_wr;
    assign rd_done          = rd_done_q;
    assign wr_done          = wr_done_q;
    assign dram_cmd_valid   = cmd_valid_q;
    assign dram_cmd_write   = cmd_write_q;
    assign dram_cmd_addr    = cmd_addr_q;
    assign dram_cmd_len     = cmd_len_q;
    assign busy             = busy_q;
    assign wr_starve_events = starve_q;

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Directed bench for dram_access_arbiter: default-parameter instance for arbitration and
// handshakes, a MAX_WAIT=4 instance for the write-starvation override.
module tb_dram_access_arbiter;

    typedef struct packed {
        logic        rd_ready;
        logic        wr_ready;
        logic        rd_done;
        logic        wr_done;
        logic        cmd_valid;
        logic        cmd_write;
        logic [38:0] cmd_addr;
        logic [7:0]  cmd_len;
        logic        busy;
        logic [15:0] starve;
    } out_t;

    typedef struct {
        logic        rv;
        logic        wv;
        logic        urg;
        logic [38:0] ra;
        logic [38:0] wa;
        logic [7:0]  rl;
        logic [7:0]  wl;
        logic        exp_wr;
        int          dly;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req_valid = 1'b0;
    logic [38:0] rd_req_addr = '0;
    logic [7:0]  rd_req_len = '0;
    logic        rd_urgent = 1'b0;
    logic        wr_req_valid = 1'b0;
    logic [38:0] wr_req_addr = '0;
    logic [7:0]  wr_req_len = '0;
    logic        dram_cmd_ready = 1'b0;
    logic        dram_done = 1'b0;

    logic        a_rd_ready, a_rd_done, a_wr_ready, a_wr_done, a_cmd_valid, a_cmd_write, a_busy;
    logic [38:0] a_cmd_addr;
    logic [7:0]  a_cmd_len;
    logic [15:0] a_starve;
    logic        b_rd_ready, b_rd_done, b_wr_ready, b_wr_done, b_cmd_valid, b_cmd_write, b_busy;
    logic [38:0] b_cmd_addr;
    logic [7:0]  b_cmd_len;
    logic [15:0] b_starve;

    out_t o0, o1;
    assign o0 = {a_rd_ready, a_wr_ready, a_rd_done, a_wr_done, a_cmd_valid, a_cmd_write,
                 a_cmd_addr, a_cmd_len, a_busy, a_starve};
    assign o1 = {b_rd_ready, b_wr_ready, b_rd_done, b_wr_done, b_cmd_valid, b_cmd_write,
                 b_cmd_addr, b_cmd_len, b_busy, b_starve};

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dram_access_arbiter dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_urgent(rd_urgent), .rd_req_ready(a_rd_ready), .rd_done(a_rd_done),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_ready(a_wr_ready), .wr_done(a_wr_done),
        .dram_cmd_valid(a_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
        .dram_cmd_write(a_cmd_write), .dram_cmd_addr(a_cmd_addr), .dram_cmd_len(a_cmd_len),
        .dram_done(dram_done), .busy(a_busy), .wr_starve_events(a_starve)
    );

    dram_access_arbiter #(.MAX_WAIT(4)) dut_s (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_urgent(rd_urgent), .rd_req_ready(b_rd_ready), .rd_done(b_rd_done),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_ready(b_wr_ready), .wr_done(b_wr_done),
        .dram_cmd_valid(b_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
        .dram_cmd_write(b_cmd_write), .dram_cmd_addr(b_cmd_addr), .dram_cmd_len(b_cmd_len),
        .dram_done(dram_done), .busy(b_busy), .wr_starve_events(b_starve)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic out_t cur(input bit sel);
        return sel ? o1 : o0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        rd_urgent = 1'b0;
        dram_cmd_ready = 1'b0;
        dram_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: present request, check the grant, run ISSUE/WAIT, check the done pulse.
    task automatic do_txn(input vec_t v, input bit sel, input string tag);
        out_t o;
        @(negedge clk);
        rd_req_valid = v.rv;  rd_req_addr = v.ra;  rd_req_len = v.rl;
        wr_req_valid = v.wv;  wr_req_addr = v.wa;  wr_req_len = v.wl;
        rd_urgent = v.urg;    dram_cmd_ready = 1'b0; dram_done = 1'b0;
        #1 o = cur(sel);
        check({tag, " rd_ready"}, o.rd_ready, !v.exp_wr);
        check({tag, " wr_ready"}, o.wr_ready, v.exp_wr);
        @(negedge clk);
        if (v.exp_wr) wr_req_valid = 1'b0;
        else rd_req_valid = 1'b0;
        dram_cmd_ready = 1'b1;
        #1 o = cur(sel);
        check({tag, " cmd_valid"}, o.cmd_valid, 1);
        check({tag, " cmd_write"}, o.cmd_write, v.exp_wr);
        check({tag, " cmd_addr"}, o.cmd_addr, v.exp_wr ? v.wa : v.ra);
        check({tag, " cmd_len"}, o.cmd_len, v.exp_wr ? v.wl : v.rl);
        check({tag, " busy"}, o.busy, 1);
        @(negedge clk);
        dram_cmd_ready = 1'b0;
        #1 o = cur(sel);
        check({tag, " cmd_valid drop"}, o.cmd_valid, 0);
        repeat (v.dly) @(negedge clk);
        dram_done = 1'b1;
        @(negedge clk);
        dram_done = 1'b0;
        #1 o = cur(sel);
        check({tag, " rd_done"}, o.rd_done, !v.exp_wr);
        check({tag, " wr_done"}, o.wr_done, v.exp_wr);
        check({tag, " busy idle"}, o.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        vec_t sv;
        out_t o;
        int   n;
        bit   done_seen;

        tbl[0] = '{rv:1, wv:0, urg:0, ra:39'h1000,  wa:39'h0,     rl:15, wl:0,  exp_wr:0, dly:10};
        tbl[1] = '{rv:0, wv:1, urg:0, ra:39'h0,     wa:39'h8000,  rl:0,  wl:7,  exp_wr:1, dly:2};
        tbl[2] = '{rv:1, wv:1, urg:0, ra:39'h1100,  wa:39'h8100,  rl:1,  wl:2,  exp_wr:0, dly:1};
        tbl[3] = '{rv:1, wv:1, urg:0, ra:39'h1200,  wa:39'h8200,  rl:3,  wl:4,  exp_wr:1, dly:0};
        tbl[4] = '{rv:1, wv:1, urg:0, ra:39'h1300,  wa:39'h8300,  rl:5,  wl:6,  exp_wr:0, dly:0};
        tbl[5] = '{rv:1, wv:1, urg:0, ra:39'h1400,  wa:39'h8400,  rl:7,  wl:8,  exp_wr:1, dly:0};
        tbl[6] = '{rv:1, wv:1, urg:1, ra:39'h1500,  wa:39'h8500,  rl:9,  wl:10, exp_wr:0, dly:2};
        tbl[7] = '{rv:1, wv:1, urg:1, ra:39'h1600,  wa:39'h8500,  rl:11, wl:10, exp_wr:0, dly:2};
        tbl[8] = '{rv:1, wv:1, urg:1, ra:39'h1700,  wa:39'h8500,  rl:13, wl:10, exp_wr:0, dly:2};
        tbl[9] = '{rv:1, wv:1, urg:0, ra:39'h1800,  wa:39'h7F_FFFF_FFFF, rl:255, wl:255, exp_wr:1, dly:1};

        // Reset state, with a read pending to show the ready pulse is held off.
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        #12;
        check("reset outputs dut", o0 == '0, 1);
        check("reset outputs dut_s", o1 == '0, 1);
        apply_reset();
        #1 check("post-release no accept", a_rd_ready, 0);

        foreach (tbl[i]) do_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));
        check("no starve events default", a_starve, 0);

        // Backpressure on the command port with a spurious done during ISSUE.
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = 39'h2_0000; rd_req_len = 8'd3;
        wr_req_valid = 1'b0; rd_urgent = 1'b0;
        #1 check("bp rd_ready", a_rd_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b1; wr_req_addr = 39'h9_0000; wr_req_len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            dram_done = (i == 2);
            #1;
            check($sformatf("bp valid c%0d", i), a_cmd_valid, 1);
            check($sformatf("bp addr c%0d", i), {a_cmd_addr, a_cmd_len}, {39'h2_0000, 8'd3});
            check($sformatf("bp no grant/done c%0d", i),
                  {a_wr_ready, a_rd_done, a_wr_done, a_busy}, 4'b0001);
            @(negedge clk);
        end
        dram_done = 1'b0;
        dram_cmd_ready = 1'b1;
        #1 check("bp valid at ready", a_cmd_valid, 1);
        @(negedge clk);
        dram_cmd_ready = 1'b0;
        #1 check("bp in wait", {a_cmd_valid, a_busy, a_rd_done}, 3'b010);
        dram_done = 1'b1;
        @(negedge clk);
        dram_done = 1'b0;
        #1 check("bp rd_done", {a_rd_done, a_wr_done}, 2'b10);
        check("bubble no wr_ready", a_wr_ready, 0);
        @(negedge clk);
        #1 check("held write accepted", a_wr_ready, 1);

        // Reset while the write sits in WAIT.
        @(negedge clk);
        wr_req_valid = 1'b0;
        dram_cmd_ready = 1'b1;
        @(negedge clk);
        dram_cmd_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 39'h3_0040; rd_req_len = 8'd31;
        #1 check("pre-reset in wait", {a_busy, a_cmd_write}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("mid-wait reset outputs", o0 == '0, 1);
        dram_done = 1'b1;
        @(negedge clk);
        dram_done = 1'b0;
        rst_n = 1'b1;
        n = 0;
        done_seen = 1'b0;
        #1;
        while (!a_rd_ready && n < 10) begin
            done_seen |= a_rd_done | a_wr_done;
            @(negedge clk);
            #1 n++;
        end
        check("rst read accepted", a_rd_ready, 1);
        check("no abandoned done", done_seen, 0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1 check("rst read cmd", {a_cmd_valid, a_cmd_write, a_cmd_addr, a_cmd_len},
                 {1'b1, 1'b0, 39'h3_0040, 8'd31});

        // Starvation override on the MAX_WAIT=4 instance.
        apply_reset();
        sv = '{rv:1, wv:1, urg:1, ra:39'h4000, wa:39'hA000, rl:2, wl:3, exp_wr:0, dly:5};
        do_txn(sv, 1'b1, "starve r1");
        check("starve count before", b_starve, 0);
        sv = '{rv:1, wv:1, urg:1, ra:39'h4100, wa:39'hA000, rl:4, wl:3, exp_wr:1, dly:1};
        do_txn(sv, 1'b1, "starve w");
        check("starve count after", b_starve, 1);
        sv = '{rv:1, wv:1, urg:1, ra:39'h4100, wa:39'hA100, rl:4, wl:5, exp_wr:0, dly:1};
        do_txn(sv, 1'b1, "starve r2");
        o = cur(1'b1);
        check("starve count hold", o.starve, 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
